// File: rtl/enemy_attack.sv
// Enemy melee attack controller: once per frame it runs IDLE->WINDUP->STRIKE->COOLDOWN
// and drives hit_en as a level. The `ENEMY_HIT_LATCH_EN macro latches hit_en for the rest of a STRIKE.
module enemy_attack #(
  parameter int unsigned WINDUP_FRAMES   = 30,
  parameter int unsigned STRIKE_FRAMES   = 20,
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter logic [9:0]  TRIGGER_RANGE   = 10'd64,
  parameter logic [9:0]  HIT_RANGE       = 10'd24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic       game_over,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [9:0] enemy_x,
  input  logic [9:0] enemy_y,
  output logic       hit_en,
  output logic [1:0] attack_state,
  output logic [7:0] strike_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WINDUP   = 2'd1,
    ST_STRIKE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  localparam logic [7:0] WINDUP_LOAD   = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] STRIKE_LOAD   = 8'(STRIKE_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES - 1);

  logic       frame_clk_delayed_q;
  logic       fe_q;
  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hit_en_q, hit_en_d;
  logic       landed_q, landed_d;
  logic [7:0] strike_count_q, strike_count_d;

  logic [9:0] dx, dy;
  logic       in_trig, contact, hit_hold, leaving_strike;

  // NOTE: synchronous reset is only seen while Clk runs; every register here, the
  // edge detector included, returns to its reset value on the first clocked edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      frame_clk_delayed_q <= 1'b0;
      fe_q                <= 1'b0;
    end else begin
      frame_clk_delayed_q <= frame_clk;
      fe_q                <= frame_clk & ~frame_clk_delayed_q;
    end
  end

  assign dx      = (player_x >= enemy_x) ? (player_x - enemy_x) : (enemy_x - player_x);
  assign dy      = (player_y >= enemy_y) ? (player_y - enemy_y) : (enemy_y - player_y);
  assign in_trig = (dx <= TRIGGER_RANGE) && (dy <= TRIGGER_RANGE);
  assign contact = (dx <= HIT_RANGE) && (dy <= HIT_RANGE);

`ifdef ENEMY_HIT_LATCH_EN
  assign hit_hold = (state_q == ST_STRIKE) && hit_en_q;
`else
  assign hit_hold = 1'b0;
`endif

  // NOTE: every *_d gets its hold value first, so no path through this block can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    hit_en_d       = hit_en_q;
    landed_d       = landed_q;
    strike_count_d = strike_count_q;
    leaving_strike = 1'b0;

    if (fe_q) begin
      if (game_over) begin
        state_d     = ST_IDLE;
        frame_cnt_d = '0;
      end else if (!enable && (state_q == ST_WINDUP || state_q == ST_STRIKE)) begin
        state_d     = ST_COOLDOWN;
        frame_cnt_d = COOLDOWN_LOAD;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (enable && in_trig) begin
              state_d     = ST_WINDUP;
              frame_cnt_d = WINDUP_LOAD;
            end
          end
          ST_WINDUP: begin
            if (frame_cnt_q == '0) begin
              state_d     = ST_STRIKE;
              frame_cnt_d = STRIKE_LOAD;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
          end
          ST_STRIKE: begin
            if (frame_cnt_q == '0) begin
              state_d     = ST_COOLDOWN;
              frame_cnt_d = COOLDOWN_LOAD;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
          end
          ST_COOLDOWN: begin
            // Exit to IDLE only; a retrigger has to wait for the following frame.
            if (frame_cnt_q == '0) begin
              state_d     = ST_IDLE;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
          end
          default: begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
          end
        endcase
      end

      hit_en_d = (state_d == ST_STRIKE) && (contact || hit_hold);

      // landed restarts on STRIKE entry and is dropped on any exit, counted or not.
      if (state_d == ST_STRIKE) begin
        landed_d = ((state_q == ST_STRIKE) && landed_q) || hit_en_d;
      end else begin
        landed_d = 1'b0;
      end

      leaving_strike = !game_over && (state_q == ST_STRIKE) && (state_d != ST_STRIKE);
      if (leaving_strike && landed_q && (strike_count_q != 8'hFF)) begin
        strike_count_d = strike_count_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= '0;
      hit_en_q       <= 1'b0;
      landed_q       <= 1'b0;
      strike_count_q <= '0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      hit_en_q       <= hit_en_d;
      landed_q       <= landed_d;
      strike_count_q <= strike_count_d;
    end
  end

  assign hit_en       = hit_en_q;
  assign attack_state = state_q;
  assign strike_count = strike_count_q;

  hit_only_in_strike: assert property (@(posedge Clk) disable iff (!Reset)
    hit_en_q |-> (state_q == ST_STRIKE));

endmodule

// File: tb/tb_enemy_attack.sv
// Self-checking bench for enemy_attack: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_enemy_attack;

  localparam int W = 2;
  localparam int S = 3;
  localparam int C = 2;
  localparam int CLK_PER_HALF_FRAME = 4;

`ifdef ENEMY_HIT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       enable = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] player_x = '0, player_y = '0, enemy_x = '0, enemy_y = '0;
  logic       hit_en;
  logic [1:0] attack_state;
  logic [7:0] strike_count;

  int checks = 0;
  int errors = 0;

  enemy_attack #(
    .WINDUP_FRAMES(W), .STRIKE_FRAMES(S), .COOLDOWN_FRAMES(C),
    .TRIGGER_RANGE(10'd64), .HIT_RANGE(10'd24)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .game_over(game_over),
    .player_x(player_x), .player_y(player_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .hit_en(hit_en), .attack_state(attack_state), .strike_count(strike_count)
  );

  always #5 Clk = ~Clk;

  // Reference model: m_t counts frames since the trigger (-1 = idle); the phase is
  // read from which window of [0,W) [W,W+S) [W+S,W+S+C) it falls into.
  int m_t = -1;
  bit m_hit = 0;
  bit m_landed = 0;
  int m_cnt = 0;

  function automatic int phase_of(input int t);
    if (t < 0) return 0;
    if (t < W) return 1;
    if (t < W + S) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_t = -1; m_hit = 0; m_landed = 0; m_cnt = 0;
  endtask

  task automatic model_fe();
    int prev_ph, dxi, dyi;
    bit trig, cont;
    prev_ph = phase_of(m_t);
    dxi = (int'(player_x) > int'(enemy_x)) ? int'(player_x) - int'(enemy_x) : int'(enemy_x) - int'(player_x);
    dyi = (int'(player_y) > int'(enemy_y)) ? int'(player_y) - int'(enemy_y) : int'(enemy_y) - int'(player_y);
    trig = (dxi <= 64) && (dyi <= 64);
    cont = (dxi <= 24) && (dyi <= 24);
    if (game_over) begin
      m_t = -1; m_hit = 0; m_landed = 0;
    end else begin
      if (!enable && (prev_ph == 1 || prev_ph == 2)) m_t = W + S;
      else if (m_t < 0) begin
        if (enable && trig) m_t = 0;
      end else begin
        m_t++;
        if (m_t == W + S + C) m_t = -1;
      end
      if (phase_of(m_t) == 2) begin
        m_hit = cont || (LATCH && prev_ph == 2 && m_hit);
        if (prev_ph != 2) m_landed = 0;
        if (m_hit) m_landed = 1;
      end else begin
        m_hit = 0;
        if (prev_ph == 2 && m_landed && m_cnt < 255) m_cnt++;
        m_landed = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame: the model steps on the same inputs, then frame_clk pulses; outputs
  // are stable (and sampled on a negedge) when the task returns.
  task automatic do_frame();
    model_fe();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (CLK_PER_HALF_FRAME) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (CLK_PER_HALF_FRAME - 1) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame();
  endtask

  task automatic set_pos(input int px, input int py, input int ex, input int ey);
    player_x = 10'(px); player_y = 10'(py); enemy_x = 10'(ex); enemy_y = 10'(ey);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, 32'(attack_state), 32'(phase_of(m_t)));
    check({tag, ".hit"},   32'(hit_en),       32'(m_hit));
    check({tag, ".count"}, 32'(strike_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic [9:0] ex, ey;
    logic [1:0] st;
    logic       hit;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Two attack cycles from idle with the player at (100,100): far, then in contact.
    for (int i = 0; i < 16; i++) begin
      vecs[i].ex = (i < 8) ? 10'd150 : 10'd120;
      vecs[i].ey = (i < 8) ? 10'd100 : 10'd110;
      vecs[i].hit = 1'b0;
      vecs[i].cnt = 8'd0;
    end
    for (int c = 0; c < 2; c++) begin
      vecs[8*c+0].st = 2'd1; vecs[8*c+1].st = 2'd1;
      vecs[8*c+2].st = 2'd2; vecs[8*c+3].st = 2'd2; vecs[8*c+4].st = 2'd2;
      vecs[8*c+5].st = 2'd3; vecs[8*c+6].st = 2'd3; vecs[8*c+7].st = 2'd0;
    end
    vecs[10].hit = 1'b1; vecs[11].hit = 1'b1; vecs[12].hit = 1'b1;
    for (int i = 13; i < 16; i++) vecs[i].cnt = 8'd1;

    // Reset
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    @(negedge Clk);
    check("reset.hit", 32'(hit_en), 32'd0);
    check("reset.state", 32'(attack_state), 32'd0);
    check("reset.count", 32'(strike_count), 32'd0);

    // Vector table
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_pos(100, 100, int'(vecs[i].ex), int'(vecs[i].ey));
      do_frame();
      check($sformatf("vec%0d.state", i), 32'(attack_state), 32'(vecs[i].st));
      check($sformatf("vec%0d.hit", i),   32'(hit_en),       32'(vecs[i].hit));
      check($sformatf("vec%0d.count", i), 32'(strike_count), 32'(vecs[i].cnt));
    end

    // Player leaves HIT_RANGE after the first contact frame
    set_pos(100, 100, 120, 110);
    frames(3);
    check("leave.first_hit", 32'(hit_en), 32'd1);
    set_pos(100, 100, 200, 100);
    do_frame();
    check("leave.fe4_hit", 32'(hit_en), 32'(LATCH));
    do_frame();
    check("leave.fe5_hit", 32'(hit_en), 32'(LATCH));
    do_frame();
    check("leave.fe6_state", 32'(attack_state), 32'd3);
    check("leave.fe6_hit", 32'(hit_en), 32'd0);
    check("leave.fe6_count", 32'(strike_count), 32'd2);
    frames(2);
    check("leave.idle", 32'(attack_state), 32'd0);

    // game_over mid-STRIKE
    set_pos(100, 100, 120, 110);
    frames(3);
    check("go.pre_hit", 32'(hit_en), 32'd1);
    game_over = 1'b1;
    do_frame();
    check("go.state", 32'(attack_state), 32'd0);
    check("go.hit", 32'(hit_en), 32'd0);
    check("go.count", 32'(strike_count), 32'd2);
    frames(2);
    check("go.frozen_state", 32'(attack_state), 32'd0);
    game_over = 1'b0;

    // enable abort from WINDUP, then trigger boundaries
    do_frame();
    check("abort.windup", 32'(attack_state), 32'd1);
    enable = 1'b0;
    do_frame();
    check("abort.cooldown", 32'(attack_state), 32'd3);
    do_frame();
    check("abort.cooldown2", 32'(attack_state), 32'd3);
    do_frame();
    check("abort.idle", 32'(attack_state), 32'd0);
    do_frame();
    check("abort.disabled_idle", 32'(attack_state), 32'd0);
    enable = 1'b1;
    set_pos(100, 100, 164, 164);
    do_frame();
    check("edge.64_trig", 32'(attack_state), 32'd1);
    frames(7);
    check("edge.64_done", 32'(attack_state), 32'd0);
    check("edge.64_count", 32'(strike_count), 32'd2);
    set_pos(100, 100, 165, 100);
    do_frame();
    check("edge.dx65", 32'(attack_state), 32'd0);
    set_pos(100, 100, 100, 165);
    do_frame();
    check("edge.dy65", 32'(attack_state), 32'd0);

    // Reset in the middle of a STRIKE, between frame edges
    set_pos(100, 100, 120, 110);
    frames(3);
    check("midrst.pre_state", 32'(attack_state), 32'd2);
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    check("midrst.state", 32'(attack_state), 32'd0);
    check("midrst.hit", 32'(hit_en), 32'd0);
    check("midrst.count", 32'(strike_count), 32'd0);

    // Saturation: land strikes until 255, then two more
    for (int k = 0; k < 300 && m_cnt < 255; k++) frames(8);
    check("sat.reach", 32'(strike_count), 32'd255);
    frames(16);
    check("sat.hold", 32'(strike_count), 32'd255);
    check_model("sat");

    // Randomized frames against the model
    for (int i = 0; i < 400; i++) begin
      int px, py;
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
      player_x = 10'(px);
      player_y = 10'(py);
      enemy_x = 10'(px + int'($urandom_range(0, 160)) - 80);
      enemy_y = 10'(py + int'($urandom_range(0, 160)) - 80);
      enable = ($urandom_range(0, 9) != 0);
      game_over = ($urandom_range(0, 19) == 0);
      do_frame();
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
